cpu_clock_controller: RTL

- Sequences the five-stage pipelined computer by issuing a single-cycle clock-enable pulse (cpu_ce) in the clk_50m domain.
- Replaces free-running divided clocks; the CPU stays on clk_50m and advances only on cpu_ce.
- Modes: halt, single-step from a push button, continuous run at one of four selectable rates, and N-step burst.
- Sits between board switches/button and the CPU top level; also drives an LED-visible CPU clock.

---
 rtl/cpu_clk_pkg.sv | 40 ++++
 rtl/cpu_clock_controller_button_debouncer.sv | 62 ++++++
 rtl/cpu_clock_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_clk_pkg.sv
// ============================================================================
// Module      : cpu_clk_pkg
// Description : Shared encodings and widths for the CPU clock-enable sequencer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_clk_pkg;

  localparam int RATE_W     = 26;
  localparam int CE_COUNT_W = 16;
  localparam int BURST_W    = 8;

  // Board switch encodings for the mode input
  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_RUN   = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  // Sequencer states; values are visible on the state output
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BURST = 2'd3
  } state_e;

  // Switch setting to the state it selects
  function automatic state_e mode_to_state(input logic [1:0] m);
    case (m)
      MODE_STEP:  return ST_STEP;
      MODE_RUN:   return ST_RUN;
      MODE_BURST: return ST_BURST;
      default:    return ST_IDLE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_clock_controller_button_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : Two-flop synchroniser, stability counter and rising-edge pulse
//               for a raw push button
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Level flips only after the synchronised input has disagreed with it for
  // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count
  always_comb begin
    sync_d  = {sync_q[0], i_btn};
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, counter, level and edge-pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_press = press_q;

endmodule

`default_nettype wire

// File: rtl/cpu_clock_controller.sv
// ============================================================================
// Module      : cpu_clock_controller
// Description : Issues single-cycle CPU clock enables in halt, single-step,
//               continuous-run and N-step burst modes
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_clock_controller
  import cpu_clk_pkg::*;
#(
  parameter int DIV0            = 50_000_000,
  parameter int DIV1            = 5_000_000,
  parameter int DIV2            = 50_000,
  parameter int DIV3            = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk_50m,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [1:0]            rate_sel,
  input  logic                  step_btn,
  input  logic [BURST_W-1:0]    burst_len,
  output logic                  cpu_ce,
  output logic                  cpu_clk_vis,
  output logic                  busy,
  output logic [1:0]            state,
  output logic [CE_COUNT_W-1:0] ce_count
);

  localparam logic [RATE_W-1:0] LAST0 = RATE_W'(DIV0 - 1);
  localparam logic [RATE_W-1:0] LAST1 = RATE_W'(DIV1 - 1);
  localparam logic [RATE_W-1:0] LAST2 = RATE_W'(DIV2 - 1);
  localparam logic [RATE_W-1:0] LAST3 = RATE_W'(DIV3 - 1);

  logic [1:0] mode_s1_q, mode_s2_q;
  // rate_s3_q is the previous synchronised value, used only to spot changes
  logic [1:0] rate_s1_q, rate_s2_q, rate_s3_q;

  logic                  press;
  state_e                state_q, state_d;
  logic [RATE_W-1:0]     rate_cnt_q, rate_cnt_d;
  logic [BURST_W-1:0]    remaining_q, remaining_d;
  logic                  busy_q, busy_d;
  logic                  ce_q, ce_d;
  logic                  vis_q, vis_d;
  logic [CE_COUNT_W-1:0] count_q, count_d;

  logic [RATE_W-1:0] rate_last;
  logic              mode_change, rate_change, counting, terminal;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk_50m),
    .rst     (reset),
    .i_btn   (step_btn),
    .o_press (press)
  );

  // Two-stage synchronisers for the quasi-static switches
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      mode_s1_q <= '0;
      mode_s2_q <= '0;
      rate_s1_q <= '0;
      rate_s2_q <= '0;
      rate_s3_q <= '0;
    end else begin
      mode_s1_q <= mode;
      mode_s2_q <= mode_s1_q;
      rate_s1_q <= rate_sel;
      rate_s2_q <= rate_s1_q;
      rate_s3_q <= rate_s2_q;
    end
  end

  // Terminal count for the currently selected rate
  always_comb begin
    case (rate_s2_q)
      2'd0:    rate_last = LAST0;
      2'd1:    rate_last = LAST1;
      2'd2:    rate_last = LAST2;
      default: rate_last = LAST3;
    endcase
  end

  // Next-state, rate counter and burst bookkeeping; mode and rate changes
  // both restart the counter and swallow a coincident terminal count
  always_comb begin
    state_d     = mode_to_state(mode_s2_q);
    mode_change = (state_d != state_q);
    rate_change = (rate_s2_q != rate_s3_q);
    counting    = (state_q == ST_RUN) ||
                  ((state_q == ST_BURST) && (remaining_q != '0));
    terminal    = counting && !mode_change && !rate_change &&
                  (rate_cnt_q == rate_last);

    remaining_d = remaining_q;
    busy_d      = busy_q;
    ce_d        = 1'b0;

    if (!counting || mode_change || rate_change || terminal) begin
      rate_cnt_d = '0;
    end else begin
      rate_cnt_d = rate_cnt_q + RATE_W'(1);
    end

    if (mode_change) begin
      remaining_d = '0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ST_RUN:  ce_d = terminal;
        ST_STEP: ce_d = press;
        ST_BURST: begin
          if (remaining_q == '0) begin
            if (press && (burst_len != '0)) begin
              remaining_d = burst_len;
              busy_d      = 1'b1;
            end
          end else if (terminal) begin
            ce_d        = 1'b1;
            remaining_d = remaining_q - BURST_W'(1);
            busy_d      = (remaining_q != BURST_W'(1));
          end
        end
        default: ce_d = 1'b0;
      endcase
    end

    vis_d   = vis_q ^ ce_d;
    count_d = count_q + CE_COUNT_W'(ce_d);
  end

  // Sequencer state and all registered outputs
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rate_cnt_q  <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      ce_q        <= 1'b0;
      vis_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rate_cnt_q  <= rate_cnt_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      ce_q        <= ce_d;
      vis_q       <= vis_d;
      count_q     <= count_d;
    end
  end

  assign cpu_ce      = ce_q;
  assign cpu_clk_vis = vis_q;
  assign busy        = busy_q;
  assign state       = state_q;
  assign ce_count    = count_q;

endmodule

`default_nettype wire
